pl_div_sequencer: RTL and testbench
===================================

# pl_div_sequencer

Multi-cycle RV32M divide/remainder unit for the pipelined core's execute stage. It sits beside the single-cycle ALU and is selected when the decoder flags a DIV/DIVU/REM/REMU instruction. It runs a radix-2 restoring division over XLEN cycles, stalls the pipeline while busy, and returns one result with a single-cycle done pulse. Divide-by-zero and signed overflow follow the RISC-V spec and complete early.

## Interface
- XLEN, 32, operand/result width; must be a power of 2, at least 8
- clk  in  1  core clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX stage holds a valid divide op; sampled only in IDLE
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other values treated as DIVU
- src_a  in  XLEN  dividend (rs1)
- src_b  in  XLEN  divisor (rs2)
- flush  in  1  branch/jump flush; aborts any operation
- stall  out  1  hold IF/ID/EX; combinational
- busy  out  1  registered; high in CALC and FIXUP
- done  out  1  registered one-cycle pulse; result valid
- result  out  XLEN  quotient or remainder; holds last value until next done

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1, flush=0:
  - Latch the op, the operand signs and the operand magnitudes. Signs are used only for DIV/REM.
  - Divisor == 0: result = all-ones for DIV/DIVU, src_a for REM/REMU. Go to DONE.
  - Signed op with src_a == 1<<(XLEN-1) and src_b == all-ones: quotient = src_a, remainder = 0. Go to DONE.
  - Otherwise: clear the partial remainder, load the quotient register with the dividend magnitude, load count = XLEN-1, go to CALC.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor, computed XLEN+1 bits wide.
  - If trial is non-negative, rem = trial and quo[0] = 1; else quo[0] = 0.
  - When count == 0, go to FIXUP; otherwise decrement count.
- FIXUP:
  - Signed ops: negate the quotient when the operand signs differ. The remainder takes the sign of the dividend.
  - Select quotient or remainder into result. Go to DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE.
- stall = (IDLE & start & ~flush) | CALC | FIXUP. It is low in DONE so the instruction retires with result.
- start is ignored outside IDLE. An immediate restart is accepted the cycle after DONE.
- flush in any state: next state IDLE, no done, result unchanged. Flush wins over start in the same cycle.
- Reset: state IDLE, busy=0, done=0, result=0, count=0, internal registers 0.

## Timing
- Start accepted at edge E0.
- Normal path: CALC for XLEN cycles, FIXUP 1 cycle, done high in cycle E0+XLEN+2. For XLEN=32 that is 34 cycles.
- Special cases (divide-by-zero, signed overflow): done high in cycle E0+1.
- result is registered and changes only on the edge that enters DONE.
- Asynchronous reset mid-operation forces IDLE immediately. No done pulse is produced for the aborted op.

## Structure
- Shared package pl_div_pkg holds:
  - the state enum (div_state_t)
  - funct3 constants FN_DIV, FN_DIVU, FN_REM, FN_REMU
  - the stall/done/result contract comment used by the EX stage
- Sub-module pl_div_step: one combinational restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in CALC.
- The count width is $clog2(XLEN).

## Test plan
- DIVU src_a=100, src_b=7 -> done at cycle 34, result=14. stall is high cycles 0..33 and low in the done cycle.
- REM src_a=-7 (0xFFFFFFF9), src_b=2 -> result=0xFFFFFFFF. DIV with the same operands -> result=0xFFFFFFFD (-3).
- DIV src_b=0, src_a=5 -> done at cycle 1, result=0xFFFFFFFF. REMU with the same operands -> result=5.
- DIV 0x80000000 / 0xFFFFFFFF -> done at cycle 1, result=0x80000000. REM with the same operands -> result=0.
- Flush at cycle 10 of CALC -> no done, busy=0 next cycle, result keeps its old value. A following DIVU 9/3 returns 3.
- start pulsed mid-CALC -> ignored, the original result is delivered. rst_n low mid-CALC -> outputs return to reset values immediately.

Source files
------------

// File: rtl/pl_div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
//
// EX-stage contract:
//   - stall is combinational. It is high from the cycle a divide op is presented in IDLE
//     (start=1, flush=0) until the cycle before done. The EX stage must hold the
//     instruction and its operands while stall is high.
//   - done is a registered single-cycle pulse. stall is low in that cycle, so the
//     instruction retires with result.
//   - result is registered. It changes only on the edge that raises done, and it holds
//     its value until the next done.
//   - flush aborts any operation. No done is produced and result is left unchanged.
package pl_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } div_state_t;

  localparam logic [2:0] FN_DIV  = 3'b100;
  localparam logic [2:0] FN_DIVU = 3'b101;
  localparam logic [2:0] FN_REM  = 3'b110;
  localparam logic [2:0] FN_REMU = 3'b111;

  // Only DIV and REM are signed. Every other encoding runs as DIVU.
  function automatic logic fn_is_signed(logic [2:0] fn);
    return (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  function automatic logic fn_is_rem(logic [2:0] fn);
    return (fn == FN_REM) || (fn == FN_REMU);
  endfunction

endpackage

// File: rtl/pl_div_sequencer_if.sv
// Handshake bundle between the EX stage (master) and the divide unit (slave).
//   start  : EX holds a valid divide op
//   funct3 : DIV/DIVU/REM/REMU select
//   src_a  : dividend (rs1)
//   src_b  : divisor (rs2)
//   flush  : abort any operation
//   stall  : hold IF/ID/EX (combinational)
//   busy   : registered, high while computing
//   done   : registered one-cycle result pulse
//   result : quotient or remainder
interface pl_div_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output stall, busy, done, result
  );

endinterface

// File: rtl/pl_div_step.sv
// One radix-2 restoring division iteration (combinational).
//   rem_i/quo_i : current partial remainder and quotient shift register
//   divisor_i   : divisor magnitude
//   rem_o/quo_o : values after shifting {rem, quo} left and doing the trial subtract
module pl_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    // Shifted remainder needs XLEN+1 bits: it can reach 2*divisor-1.
    rem_sh = {rem_i, quo_i[XLEN-1]};
    trial  = rem_sh - {1'b0, divisor_i};
    if (!trial[XLEN]) begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/pl_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the execute stage.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pl_div_sequencer_if (start/funct3/src_a/src_b/flush in,
//           stall/busy/done/result out)
// Sign-magnitude flow: operands are made non-negative, XLEN restoring steps run one per
// cycle, and signs are re-applied in FIXUP. Divide-by-zero and signed overflow skip
// straight to DONE.
module pl_div_sequencer
  import pl_div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pl_div_sequencer_if.slave bus
);

  localparam int unsigned     CntW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_rem_q, is_rem_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            op_signed, op_rem, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] quo_fix, rem_fix;

  pl_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    op_signed = fn_is_signed(bus.funct3);
    op_rem    = fn_is_rem(bus.funct3);
    a_neg     = op_signed & bus.src_a[XLEN-1];
    b_neg     = op_signed & bus.src_b[XLEN-1];
    // MinNeg negates to itself, which is still the correct unsigned magnitude.
    a_mag     = a_neg ? -bus.src_a : bus.src_a;
    b_mag     = b_neg ? -bus.src_b : bus.src_b;
    // Signs are only ever latched for signed ops, so no separate signed flag is kept.
    quo_fix   = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_fix   = sign_a_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;

    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            is_rem_d = op_rem;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            if (bus.src_b == '0) begin
              result_d = op_rem ? bus.src_a : '1;
              state_d  = StDone;
            end else if (op_signed && (bus.src_a == MinNeg) && (bus.src_b == '1)) begin
              result_d = op_rem ? '0 : bus.src_a;
              state_d  = StDone;
            end else begin
              rem_d   = '0;
              quo_d   = a_mag;
              dvs_d   = b_mag;
              cnt_d   = CntW'(XLEN - 1);
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            state_d = StFixup;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StFixup: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = StDone;
        end
        StDone: begin
          state_d = StIdle;
        end
      endcase
    end

    // Registered status outputs follow the state being entered.
    busy_d = (state_d == StCalc) || (state_d == StFixup);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.stall  = ((state_q == StIdle) && bus.start && !bus.flush) ||
                      (state_q == StCalc) || (state_q == StFixup);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_pl_div_sequencer.sv
// Bench for pl_div_sequencer (XLEN=32): directed ops followed by randomized ops with
// random flushes, ignored mid-op start pulses and a mid-op reset. The expected results
// come from plain integer division; the expected cycle-by-cycle stall/busy/done/result
// waveform comes from the latency rules.
module tb_pl_div_sequencer;
  import pl_div_pkg::*;

  logic clk;
  logic rst_n;

  pl_div_sequencer_if #(.XLEN(32)) bus ();

  pl_div_sequencer #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model of the op in flight, written only by the stimulus process.
  bit          op_valid  = 1'b0;
  int          start_cyc = 0;
  int          cur_L     = 0;
  int          cur_fk    = 1000;
  logic [31:0] cur_res   = '0;
  logic [31:0] prev_res  = '0;
  logic [31:0] last_res  = '0;
  bit          lit_valid = 1'b0;
  logic [31:0] lit_val   = '0;

  function automatic bit is_special(logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    return (b == 0) ||
           (((fn == 3'b100) || (fn == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    bit     ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (fn)
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      3'b111: begin
        if (b == 0) return a;
        return a % b;
      end
      default: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pin_model();
    check("pin_divu_100_7",  ref_result(FN_DIVU, 100, 7), 32'd14);
    check("pin_rem_m7_2",    ref_result(FN_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    check("pin_div_m7_2",    ref_result(FN_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    check("pin_div_by0",     ref_result(FN_DIV, 5, 0), 32'hFFFF_FFFF);
    check("pin_remu_by0",    ref_result(FN_REMU, 5, 0), 32'd5);
    check("pin_div_ovf",     ref_result(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_rem_ovf",     ref_result(FN_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
    check("pin_div_neg_div", ref_result(FN_DIV, 12345, 32'hFFFF_FFFB), 32'hFFFF_F65B);
  endtask

  // Compare process: every cycle, at the falling edge.
  initial begin
    int k;
    bit aborted, completed;
    bit e_stall, e_busy, e_done;
    logic [31:0] e_res;
    forever begin
      @(negedge clk);
      if (cyc == 0) pin_model();
      if (!op_valid) begin
        e_stall = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_res   = last_res;
        k       = -1;
        completed = 1'b0;
      end else begin
        k         = cyc - start_cyc;
        aborted   = k > cur_fk;
        completed = cur_fk >= cur_L;
        e_stall   = (k < cur_L) && !aborted && !((k == 0) && (cur_fk == 0));
        e_busy    = (k >= 1) && (k < cur_L) && !aborted;
        e_done    = completed && (k == cur_L);
        e_res     = (completed && (k >= cur_L)) ? cur_res : prev_res;
      end
      check("stall",  32'(bus.stall), 32'(e_stall));
      check("busy",   32'(bus.busy),  32'(e_busy));
      check("done",   32'(bus.done),  32'(e_done));
      check("result", bus.result, e_res);
      if (op_valid && lit_valid && completed && (k == cur_L)) begin
        check("literal_result", bus.result, lit_val);
      end
      cyc++;
    end
  end

  // Issue one op at the current cycle (entered just after a rising edge).
  // fk: flush cycle (1000 = none); sp: ignored start pulse cycle (0 = none);
  // rk: reset cycle (0 = none).
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int fk, input int sp, input int rk,
                        input bit has_lit, input logic [31:0] lit);
    int L, k, end_k, sp_eff;
    logic [31:0] r;
    L      = is_special(fn, a, b) ? 1 : 34;
    r      = ref_result(fn, a, b);
    sp_eff = ((sp < L) && (sp < fk)) ? sp : 0;
    end_k  = (fk < L) ? fk : L;
    bus.funct3 = fn;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.start  = 1'b1;
    bus.flush  = (fk == 0);
    cur_L      = L;
    cur_fk     = fk;
    cur_res    = r;
    prev_res   = last_res;
    lit_valid  = has_lit;
    lit_val    = lit;
    start_cyc  = cyc;
    op_valid   = 1'b1;
    k = 0;
    while (1) begin
      @(posedge clk);
      #2;
      k++;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (k > end_k) break;
      if (k == rk) begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        last_res = '0;
        repeat (2) begin
          @(posedge clk);
          #2;
        end
        rst_n = 1'b1;
        return;
      end
      if (k == fk) bus.flush = 1'b1;
      if (k == sp_eff) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'($urandom);
        bus.src_a  = $urandom;
        bus.src_b  = $urandom;
      end
    end
    if (fk >= L) last_res = r;
  endtask

  initial begin
    logic [2:0]  fn;
    logic [31:0] a, b;
    int mode, fk, sp;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run_op(FN_DIVU, 100, 7, 1000, 0, 0, 1'b1, 32'd14);
    run_op(FN_REM, 32'hFFFF_FFF9, 2, 1000, 0, 0, 1'b1, 32'hFFFF_FFFF);
    run_op(FN_DIV, 32'hFFFF_FFF9, 2, 1000, 0, 0, 1'b1, 32'hFFFF_FFFD);
    run_op(FN_DIV, 5, 0, 1000, 0, 0, 1'b1, 32'hFFFF_FFFF);
    run_op(FN_REMU, 5, 0, 1000, 0, 0, 1'b1, 32'd5);
    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1000, 0, 0, 1'b1, 32'h8000_0000);
    run_op(FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1000, 0, 0, 1'b1, 32'h0);
    run_op(FN_DIVU, 1000, 3, 10, 0, 0, 1'b0, 32'h0);
    run_op(FN_DIVU, 9, 3, 1000, 0, 0, 1'b1, 32'd3);
    run_op(FN_DIV, 12345, 32'hFFFF_FFFB, 1000, 12, 0, 1'b1, 32'hFFFF_F65B);
    run_op(FN_REMU, 32'hDEAD_BEEF, 17, 1000, 0, 15, 1'b0, 32'h0);
    run_op(FN_DIVU, 50, 5, 0, 0, 0, 1'b0, 32'h0);
    run_op(FN_DIVU, 50, 5, 1000, 0, 0, 1'b1, 32'd10);

    for (int i = 0; i < 40; i++) begin
      fn   = 3'($urandom);
      a    = $urandom;
      b    = $urandom >> $urandom_range(0, 31);
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        b = 0;
      end else if (mode == 1) begin
        fn = $urandom_range(0, 1) ? FN_DIV : FN_REM;
        a  = 32'h8000_0000;
        b  = 32'hFFFF_FFFF;
      end else if (mode == 2) begin
        a = $urandom_range(0, 200);
        b = $urandom_range(1, 15);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      fk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 34)) : 1000;
      sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
      run_op(fn, a, b, fk, sp, 0, 1'b0, 32'h0);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
